wb_bram_slave: RTL
==================

Name: wb_bram_slave

Overview:
Wishbone B3 slave wrapping a single-port on-chip word memory. It is the downstream target of the CPU's cache/memory control unit's Wishbone master port. It supports classic single cycles and registered-feedback bursts (constant and incrementing, with linear or wrap-4/8/16 addressing), byte-lane writes and out-of-range error reporting. It gives the CMU a deterministic memory target for cache line fills and write-backs.

Parameters:
ADDR_WIDTH, 10, word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words
BASE_ADDR, 32'h0000_0000, byte base address; only bits [31:ADDR_WIDTH+2] are compared
WAIT_CYCLES, 0, extra wait states inserted before the first ack of every access (0..15)

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
wbs_cyc_i  in  1  bus cycle in progress
wbs_stb_i  in  1  strobe, beat valid
wbs_addr_i  in  30  word address [31:2]
wbs_cti_i  in  3  cycle type: 000 classic, 001 const burst, 010 incr burst, 111 end of burst
wbs_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
wbs_sel_i  in  4  byte enables; bit n covers data[8n+7:8n]
wbs_we_i  in  1  1 = write, 0 = read
wbs_data_i  in  32  write data
wbs_data_o  out  32  read data, valid only while wbs_ack_o is high
wbs_ack_o  out  1  beat acknowledge
wbs_err_o  out  1  error termination

Behaviour:
- Reset: wbs_ack_o=0, wbs_err_o=0, wbs_data_o=0, FSM=IDLE, wait counter=0. Memory contents are not reset. Reset asserted mid-burst aborts the burst: no ack in the following cycle and no pending write is performed.
- FSM states: IDLE, WAIT, SINGLE, BURST, ERR.
- IDLE: cyc&stb sampled in cycle N.
  - Address out of range, or cti in 011..110 -> ERR. wbs_err_o=1 in N+1 for one cycle, then IDLE. No memory write.
  - Otherwise latch the address, we and bte. If WAIT_CYCLES>0, go to WAIT. Else go to SINGLE (cti 000 or 111) or BURST (cti 001/010).
- WAIT: count WAIT_CYCLES cycles, then go to SINGLE or BURST. The first ack is in cycle N+1+WAIT_CYCLES.
- SINGLE: wbs_ack_o=1 for exactly one cycle, then IDLE with ack=0 even if stb stays high. Back-to-back classic accesses with WAIT_CYCLES=0 are acked every second cycle.
- BURST:
  - ack is high in every cycle where cyc&stb are high, starting with the first beat.
  - Beat address comes from an internal counter, not wbs_addr_i after the first beat.
  - Counter advances after each acked beat. cti=001 holds the address. cti=010 increments per bte.
  - Linear increments modulo 2^ADDR_WIDTH, wrapping to the region base. wrapK keeps addr[31:2+log2K] fixed and wraps the low log2K bits.
  - Read data for the current beat address is presented together with ack, with zero bubbles between beats. This requires read-ahead of the next address.
  - stb low mid-burst (master wait): ack=0, counter holds, resume on stb high.
  - Beat sampled with cti=111 is acked as the last beat, then IDLE.
  - cyc low at any time: IDLE next cycle, no further ack.
- Writes:
  - Performed only in a cycle where ack=1, using wbs_data_i and wbs_sel_i sampled in that cycle.
  - sel=0000 is acked with no change to memory.
  - Reads ignore sel and always return the full word.
- ack and err are never high in the same cycle. err is never asserted inside an accepted burst.
- wbs_data_o may hold stale data while ack=0.

Test Plan:
- Classic read: preload word 0x004=0xDEADBEEF; cyc/stb, addr=0x001 (byte 0x004), cti=000, WAIT_CYCLES=0 -> ack high exactly in cycle N+1 with data_o=0xDEADBEEF, ack low in N+2.
- Byte-lane write: word 0x010 = 0x11223344; write data 0xAABBCCDD, sel=0101 -> read back 0x11BB33DD.
- Wrap-4 incr read burst: cti=010, bte=01, start word 6; words 4..7 = 4,5,6,7 -> four consecutive acks with data 6,7,4,5; last beat cti=111; ack low next cycle.
- Master wait mid-burst: 8-beat linear write burst with stb low for 2 cycles after beat 3 -> no ack during the gap, 8 writes total, addresses contiguous.
- Error and abort: addr outside BASE_ADDR region -> err for 1 cycle, no ack, memory unchanged. Drop cyc after beat 2 of a write burst -> only 2 words written.
- Wait states: WAIT_CYCLES=3, classic read -> ack at cycle N+4. Reset pulsed during the WAIT state -> no ack, FSM back to IDLE.

Source files
------------

// File: rtl/wb_bram_slave.sv
// Wishbone B3 slave over a single-port 32-bit word memory.
// Classic cycles plus registered-feedback bursts (constant / incrementing,
// linear or wrap-4/8/16), byte-lane writes, optional wait states and
// error termination for out-of-region or reserved-cti accesses.
module wb_bram_slave #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic [29:0] wbs_addr_i,
   input  logic [2:0]  wbs_cti_i,
   input  logic [1:0]  wbs_bte_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_we_i,
   input  logic [31:0] wbs_data_i,
   output logic [31:0] wbs_data_o,
   output logic        wbs_ack_o,
   output logic        wbs_err_o
);

   localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
   localparam logic [3:0]  WaitLast = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StWait, StSingle, StBurst, StErr} state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic                  burst_q;
   logic [1:0]            bte_q;
   logic [3:0]            wait_q;
   logic                  ack_q;
   logic                  err_q;
   logic [31:0]           data_q;

   logic [31:0]           mem [Depth];

   logic                  req;
   logic                  in_range;
   logic                  cti_bad;
   logic                  cti_burst;
   logic                  beat;
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic [ADDR_WIDTH-1:0] addr_step;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [ADDR_WIDTH-1:0] rd_addr;

   assign req       = wbs_cyc_i & wbs_stb_i;
   assign in_range  = (wbs_addr_i[29:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH+2]);
   assign cti_bad   = (wbs_cti_i == 3'b011) | (wbs_cti_i[2] & (wbs_cti_i != 3'b111));
   assign cti_burst = (wbs_cti_i == 3'b001) | (wbs_cti_i == 3'b010);
   // ack_q means "data/slot ready"; the visible ack also needs the master to be strobing
   assign beat      = ack_q & req;

   assign wbs_ack_o  = beat;
   assign wbs_err_o  = err_q;
   assign wbs_data_o = data_q;

   // Low address bits that wrap for the latched burst type (all bits for linear)
   always_comb begin
      wrap_mask = '1;
      unique case (bte_q)
         2'b01:   wrap_mask = ADDR_WIDTH'(3);
         2'b10:   wrap_mask = ADDR_WIDTH'(7);
         2'b11:   wrap_mask = ADDR_WIDTH'(15);
         default: wrap_mask = '1;
      endcase
   end

   // Next beat address and the word to read ahead into the data register
   always_comb begin
      addr_step = (addr_q & ~wrap_mask) | ((addr_q + ADDR_WIDTH'(1)) & wrap_mask);
      addr_nxt  = (wbs_cti_i == 3'b010) ? addr_step : addr_q;
      rd_addr   = addr_q;
      if (state_q == StIdle) begin
         rd_addr = wbs_addr_i[ADDR_WIDTH-1:0];
      end else if ((state_q == StBurst) && beat) begin
         rd_addr = addr_nxt;
      end
   end

   // Bus FSM with registered ack-ready, err and read data
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         we_q    <= 1'b0;
         burst_q <= 1'b0;
         bte_q   <= 2'b00;
         wait_q  <= 4'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= 32'h0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            StIdle: begin
               ack_q  <= 1'b0;
               wait_q <= 4'd0;
               if (req) begin
                  if (!in_range || cti_bad) begin
                     state_q <= StErr;
                     err_q   <= 1'b1;
                  end else begin
                     addr_q  <= wbs_addr_i[ADDR_WIDTH-1:0];
                     we_q    <= wbs_we_i;
                     bte_q   <= wbs_bte_i;
                     burst_q <= cti_burst;
                     if (WAIT_CYCLES == 0) begin
                        state_q <= cti_burst ? StBurst : StSingle;
                        ack_q   <= 1'b1;
                        data_q  <= mem[rd_addr];
                     end else begin
                        state_q <= StWait;
                     end
                  end
               end
            end
            StWait: begin
               if (!wbs_cyc_i) begin
                  state_q <= StIdle;
               end else if (wait_q == WaitLast) begin
                  state_q <= burst_q ? StBurst : StSingle;
                  ack_q   <= 1'b1;
                  data_q  <= mem[rd_addr];
               end else begin
                  wait_q <= wait_q + 4'd1;
               end
            end
            StSingle: begin
               // Exactly one ack; a held strobe does not earn a second one
               if (!wbs_cyc_i || wbs_stb_i) begin
                  state_q <= StIdle;
                  ack_q   <= 1'b0;
               end
            end
            StBurst: begin
               if (!wbs_cyc_i) begin
                  state_q <= StIdle;
                  ack_q   <= 1'b0;
               end else if (beat) begin
                  if (!cti_burst) begin
                     state_q <= StIdle;
                     ack_q   <= 1'b0;
                  end else begin
                     addr_q <= addr_nxt;
                     data_q <= mem[rd_addr];
                  end
               end
            end
            StErr: begin
               state_q <= StIdle;
               ack_q   <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

   // Byte-lane write on every acknowledged write beat; suppressed while in reset
   always_ff @(posedge clk) begin
      if (!rst && beat && we_q) begin
         for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) begin
               mem[addr_q][8*b +: 8] <= wbs_data_i[8*b +: 8];
            end
         end
      end
   end

endmodule
